// File: rtl/bounded_updown_counter_if.sv
// bounded_updown_counter_if: control and status bundle for the bounded up/down counter
interface bounded_updown_counter_if #(parameter int N = 8, parameter int S = 8);
  logic syn_clr, load, start, en, up;
  logic [N-1:0] load_val, lo_lim, hi_lim, cnt;
  logic [S-1:0] step;
  logic [1:0] mode;
  logic max_tick, min_tick, wrap_pulse, done, busy, cfg_err;
  modport master(
    output syn_clr, load, load_val, start, en, up, step, lo_lim, hi_lim, mode,
    input cnt, max_tick, min_tick, wrap_pulse, done, busy, cfg_err
  );
  modport slave(
    input syn_clr, load, load_val, start, en, up, step, lo_lim, hi_lim, mode,
    output cnt, max_tick, min_tick, wrap_pulse, done, busy, cfg_err
  );
endinterface

// File: rtl/bounded_updown_counter.sv
// bounded_updown_counter: up/down counter with programmable limits, step and wrap/saturate/one-shot modes
module bounded_updown_counter #(parameter int N = 8, parameter int S = 8) (
  input logic clk,
  input logic rst_n,
  bounded_updown_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [N-1:0] cnt, cnt_nxt, ld_lo, ld, nxt_in;
  logic wrap_pulse, wrap_nxt, done, done_nxt;
  logic [N:0] cnt_x, lo_x, hi_x, step_x, sum, dif, lo_step;
  logic count, over, land, stray, wrap_m, shot_m;
  assign cnt_x = {1'b0, cnt};
  assign lo_x = {1'b0, bus.lo_lim};
  assign hi_x = {1'b0, bus.hi_lim};
  assign step_x = {{(N + 1 - S){1'b0}}, bus.step};
  assign sum = cnt_x + step_x;
  assign dif = cnt_x - step_x;
  assign lo_step = lo_x + step_x;
  assign over = bus.up ? sum > hi_x : cnt_x < lo_step;
  assign land = bus.up ? sum == hi_x : cnt_x == lo_step;
  assign nxt_in = bus.up ? sum[N-1:0] : dif[N-1:0];
  // cnt left outside the range by a limit change is snapped to the bound it violates
  assign stray = cnt < bus.lo_lim || cnt > bus.hi_lim;
  assign wrap_m = bus.mode == 2'd0 || bus.mode == 2'd3;
  assign shot_m = bus.mode == 2'd2;
  assign ld_lo = bus.load_val < bus.lo_lim ? bus.lo_lim : bus.load_val;
  assign ld = ld_lo > bus.hi_lim ? bus.hi_lim : ld_lo;
  assign bus.cfg_err = bus.lo_lim > bus.hi_lim;
  assign count = state == RUN && bus.en && !bus.cfg_err && bus.step != '0;
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    wrap_nxt = 1'b0;
    done_nxt = done;
    if (bus.syn_clr) begin
      state_nxt = IDLE;
      cnt_nxt = bus.up ? bus.lo_lim : bus.hi_lim;
      done_nxt = 1'b0;
    end else if (bus.load) begin
      state_nxt = state == DONE ? IDLE : state;
      cnt_nxt = ld;
      done_nxt = 1'b0;
    end else begin
      if (state == IDLE && bus.start) state_nxt = RUN;
      if (count) begin
        if (stray) cnt_nxt = cnt < bus.lo_lim ? bus.lo_lim : bus.hi_lim;
        else if (over) begin
          cnt_nxt = (wrap_m ^ bus.up) ? bus.hi_lim : bus.lo_lim;
          wrap_nxt = wrap_m;
        end else cnt_nxt = nxt_in;
        if (!stray && shot_m && (over || land)) begin
          done_nxt = 1'b1;
          state_nxt = DONE;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      wrap_pulse <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      wrap_pulse <= wrap_nxt;
      done <= done_nxt;
    end
  end
  assign bus.cnt = cnt;
  assign bus.wrap_pulse = wrap_pulse;
  assign bus.done = done;
  assign bus.busy = state == RUN;
  assign bus.max_tick = cnt == bus.hi_lim;
  assign bus.min_tick = cnt == bus.lo_lim;
endmodule
